mem_master: RTL and testbench

- Write initiator for the 3-bit address / 3-bit value valid/ready memory write interface.
- Buffers upstream write requests in a small FIFO.
- Drives the memory-side valid, address and value, and holds them stable until the memory target accepts with ready.
- Counts completed writes and flags a stalled target. Sits between test or control logic and the memory slave.

---
 rtl/mem_master.sv | 121 ++++++++++++
 tb/tb_mem_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// Write initiator: queues upstream write requests in a small FIFO and issues them
// over a valid/ready memory write port, counting completions and flagging stalls.
module mem_master #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_value,
  output logic              req_ready,
  output logic              valid,
  output logic [ADDR_W-1:0] data_in_addr,
  output logic [DATA_W-1:0] data_in_value,
  input  logic              ready,
  output logic [7:0]        wr_count,
  output logic              idle,
  output logic              timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state;

  logic [ADDR_W-1:0] fifo_addr  [DEPTH];
  logic [DATA_W-1:0] fifo_value [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       occ;
  logic [SW-1:0]     stall_cnt;
  logic              push;
  logic              pop;
  logic              handshake;
  logic              fifo_empty;

  // Both sides use valid/ready: a transfer happens on a rising edge where both are
  // high; the initiator holds valid and its payload unchanged until that edge.
  assign fifo_empty = (occ == '0);
  assign req_ready  = (occ < (PW+1)'(DEPTH));
  assign push       = req_valid && req_ready;
  assign handshake  = valid && ready;
  assign pop        = !fifo_empty && ((state == IDLE) || handshake);
  assign idle       = fifo_empty && !valid;

  // Storage needs no reset: entries are only read behind the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_value[wr_ptr] <= req_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid         <= 1'b0;
      data_in_addr  <= '0;
      data_in_value <= '0;
      wr_count      <= '0;
      stall_cnt     <= '0;
      timeout_err   <= 1'b0;
    end else begin
      if (handshake) wr_count <= wr_count + 8'd1;

      // Stall timer saturates; the error flag is sticky until reset.
      if (!valid || handshake)
        stall_cnt <= '0;
      else if (stall_cnt != SW'(TIMEOUT))
        stall_cnt <= stall_cnt + 1'b1;
      if (valid && !ready && stall_cnt == SW'(TIMEOUT - 1))
        timeout_err <= 1'b1;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            data_in_addr  <= fifo_addr[rd_ptr];
            data_in_value <= fifo_value[rd_ptr];
            valid         <= 1'b1;
            state         <= SEND;
          end else begin
            valid <= 1'b0;
          end
        end
        SEND: begin
          if (handshake) begin
            if (!fifo_empty) begin
              data_in_addr  <= fifo_addr[rd_ptr];
              data_in_value <= fifo_value[rd_ptr];
            end else begin
              valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: directed pushes feed an expected queue; a negedge monitor
// pops it on every memory-side handshake and checks payload hold while stalled.
module tb_mem_master;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 3;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_value;
  logic              req_ready;
  logic              valid;
  logic [ADDR_W-1:0] data_in_addr;
  logic [DATA_W-1:0] data_in_value;
  logic              ready;
  logic [7:0]        wr_count;
  logic              idle;
  logic              timeout_err;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;

  mem_master #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_value(req_value), .req_ready(req_ready),
    .valid(valid), .data_in_addr(data_in_addr), .data_in_value(data_in_value), .ready(ready),
    .wr_count(wr_count), .idle(idle), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: sample at negedge, where inputs driven after posedge are settled.
  logic              prev_hold = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_value;
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] e;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", valid, 1);
        check("hold_addr", data_in_addr, prev_addr);
        check("hold_value", data_in_value, prev_value);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("write_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", data_in_addr, e[ADDR_W+DATA_W-1:DATA_W]);
          check("wr_value", data_in_value, e[DATA_W-1:0]);
        end
        n_writes++;
      end
      prev_hold  = valid && !ready;
      prev_addr  = data_in_addr;
      prev_value = data_in_value;
    end
  end

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    bit acc = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_value = v;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    if (acc) exp_q.push_back({a, v});
    check("push_accepted", int'(acc), 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = idle;
    end
    check("drain_idle", int'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    req_valid = 1'b0;
    req_addr  = '0;
    req_value = '0;
    ready     = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    check("rst_req_ready", req_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_valid", valid, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_addr", data_in_addr, 0);

    // Single write: one-edge latency from push to valid, held until ready.
    push(3'd5, 3'd3);
    check("no_bypass_valid", valid, 0);
    step(1);
    check("single_valid", valid, 1);
    check("single_addr", data_in_addr, 5);
    check("single_value", data_in_value, 3);
    step(3);
    check("single_still_valid", valid, 1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("single_wr_count", wr_count, 1);
    check("single_valid_low", valid, 0);
    check("single_idle", idle, 1);

    // Fill: one entry sits in the output register, four in the FIFO.
    for (int i = 0; i < 5; i++) push(3'(i), 3'(7 - i));
    check("full_req_ready", req_ready, 0);
    req_valid = 1'b1;
    req_addr  = 3'd5;
    req_value = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_reject", req_ready, 0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b2b_valid", valid, 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("b2b_done_valid", valid, 0);
    check("b2b_wr_count", wr_count, 6);
    @(posedge clk);
    #1;
    ready = 1'b0;

    // Slow target with randomized ready gaps, 20 requests.
    fork
      begin
        for (int i = 0; i < 20; i++) push(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
      begin
        int g = 0;
        while (n_writes < 26 && g < 300) begin
          step($urandom_range(5, 11));
          ready = 1'b1;
          step(1);
          ready = 1'b0;
          g++;
        end
      end
    join
    check("slave_wr_count", wr_count, 26);
    check("slave_idle", idle, 1);

    // Stall until the timeout fires; valid must persist.
    push(3'd2, 3'd6);
    step(1);
    check("to_valid", valid, 1);
    step(TIMEOUT - 1);
    check("to_err_before", timeout_err, 0);
    step(1);
    check("to_err_set", timeout_err, 1);
    step(5);
    check("to_err_sticky", timeout_err, 1);
    check("to_valid_held", valid, 1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("to_wr_count", wr_count, 27);
    check("to_valid_low", valid, 0);
    check("to_err_after", timeout_err, 1);

    // Asynchronous reset in SEND with two entries queued.
    push(3'd1, 3'd1);
    push(3'd2, 3'd2);
    push(3'd3, 3'd3);
    check("mid_valid", valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", valid, 0);
    check("arst_idle", idle, 1);
    check("arst_wr_count", wr_count, 0);
    check("arst_timeout_err", timeout_err, 0);
    check("arst_req_ready", req_ready, 1);
    exp_q.delete();
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("post_rst_valid", valid, 0);
    end

    // 256 writes wrap the counter.
    ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      push(b[2:0], b[5:3]);
    end
    wait_idle();
    check("wrap_wr_count", wr_count, 0);
    ready = 1'b0;

    // Push and pop on the same edge at occupancy 2.
    push(3'd1, 3'd2);
    push(3'd2, 3'd3);
    push(3'd3, 3'd4);
    ready = 1'b1;
    push(3'd4, 3'd5);
    ready = 1'b0;
    check("pp_req_ready", req_ready, 1);
    push(3'd5, 3'd6);
    push(3'd6, 3'd7);
    check("pp_full", req_ready, 0);
    ready = 1'b1;
    wait_idle();
    ready = 1'b0;
    check("pp_wr_count", wr_count, 6);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
